// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial shifter with valid/ready intake; LSB-first order when SERIALIZER_LSB_FIRST_EN is defined
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             x,
  output logic             x_valid,
  output logic             word_done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic             last, accept, load_bit, next_bit;
  logic [WIDTH-1:0] load_rest, next_rest;
`ifdef SERIALIZER_LSB_FIRST_EN
  assign load_bit  = in_data[0];
  assign load_rest = in_data >> 1;
  assign next_bit  = sreg[0];
  assign next_rest = sreg >> 1;
`else
  assign load_bit  = in_data[WIDTH-1];
  assign load_rest = in_data << 1;
  assign next_bit  = sreg[WIDTH-1];
  assign next_rest = sreg << 1;
`endif
  assign last     = state == SHIFT && cnt == '0 && bit_en;
  assign in_ready = state == IDLE || last;
  assign accept   = in_valid && in_ready;
  // load on accept, advance on bit_en, return to idle after the last bit unless a new word follows
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sreg      <= '0;
      x         <= 1'b0;
      x_valid   <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= last;
      if (accept) begin
        state   <= SHIFT;
        cnt     <= CW'(WIDTH - 1);
        sreg    <= load_rest;
        x       <= load_bit;
        x_valid <= 1'b1;
      end else if (last) begin
        state   <= IDLE;
        x       <= 1'b0;
        x_valid <= 1'b0;
      end else if (state == SHIFT && bit_en) begin
        cnt  <= cnt - 1'b1;
        sreg <= next_rest;
        x    <= next_bit;
      end
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed checks of serializer order, handshake, stall, reset abort and a downstream "110" detector
module tb_bit_serializer;
  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, bit_en, x, x_valid, word_done;
  logic [7:0] in_data;
  logic [7:0] s1;
  logic [1:0] det;
  logic       det_out;
  int         passed = 0;
  int         total = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bit_en(bit_en), .x(x), .x_valid(x_valid), .word_done(word_done)
  );

  // Mealy detector for "110" fed by the serial stream
  always_ff @(posedge clk) begin
    if (reset) det <= 2'd0;
    else if (x_valid && bit_en) det <= x ? (det == 2'd0 ? 2'd1 : 2'd2) : 2'd0;
  end
  assign det_out = x_valid && det == 2'd2 && !x;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic eb(input logic [7:0] w, input int i);
`ifdef SERIALIZER_LSB_FIRST_EN
    return w[i];
`else
    return w[7-i];
`endif
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; bit_en = 1'b0; in_data = 8'h00;
    tick; tick;
    reset = 1'b0;
    tick;
    chk("rst_x", x, 0);
    chk("rst_xv", x_valid, 0);
    chk("rst_wd", word_done, 0);
    chk("rst_rdy", in_ready, 1);

`ifdef SERIALIZER_LSB_FIRST_EN
    s1 = 8'b01101101;
`else
    s1 = 8'b10110110;
`endif
    in_data = 8'b10110110; in_valid = 1'b1; bit_en = 1'b1;
    chk("t1_rdy", in_ready, 1);
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t1_x", x, s1[7-i]);
      chk("t1_xv", x_valid, 1);
      chk("t1_wd", word_done, 0);
      tick;
    end
    chk("t1_done", word_done, 1);
    chk("t1_idle_xv", x_valid, 0);
    chk("t1_idle_x", x, 0);
    bit_en = 1'b0;
    chk("t1_idle_rdy", in_ready, 1);
    tick;
    chk("t1_done_off", word_done, 0);

    bit_en = 1'b1; in_data = 8'hA5; in_valid = 1'b1;
    chk("t2_rdy0", in_ready, 1);
    tick;
    in_data = 8'h3C;
    for (int c = 1; c <= 16; c++) begin
      chk("t2_x", x, c <= 8 ? eb(8'hA5, c - 1) : eb(8'h3C, c - 9));
      chk("t2_xv", x_valid, 1);
      chk("t2_wd", word_done, c == 9);
      if (c <= 15) chk("t2_rdy", in_ready, c == 8);
      tick;
      if (c == 8) in_valid = 1'b0;
    end
    chk("t2_done", word_done, 1);
    chk("t2_idle", x_valid, 0);
    tick;

    in_data = 8'hF0; in_valid = 1'b1; bit_en = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      bit_en = !(c >= 2 && c <= 4);
      chk("t3_x", x, eb(8'hF0, c <= 2 ? c - 1 : (c <= 5 ? 1 : c - 4)));
      chk("t3_xv", x_valid, 1);
      chk("t3_wd", word_done, 0);
      if (c == 2) chk("t3_stall_rdy", in_ready, 0);
      tick;
    end
    chk("t3_done", word_done, 1);
    chk("t3_idle", x_valid, 0);
    tick;

    in_data = 8'hFF; in_valid = 1'b1; bit_en = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) tick;
    chk("t4_x4", x, 1);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    tick;
    reset = 1'b0; in_valid = 1'b0;
    chk("t4_x", x, 0);
    chk("t4_xv", x_valid, 0);
    chk("t4_rdy", in_ready, 1);
    for (int c = 0; c < 8; c++) begin
      chk("t4_wd", word_done, 0);
      chk("t4_noacc", x_valid, 0);
      tick;
    end

    in_data = 8'b01101100; in_valid = 1'b1; bit_en = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("t5_x", x, eb(8'b01101100, c - 1));
`ifdef SERIALIZER_LSB_FIRST_EN
      chk("t5_det", det_out, c == 5 || c == 8);
`else
      chk("t5_det", det_out, c == 4 || c == 7);
`endif
      tick;
    end
    chk("t5_done", word_done, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
